// File: rtl/fourier_result_sequencer.sv
// Reads N_POINTS result words out of a Fourier core once it reports completion,
// streaming them over a valid/ready interface with a wait timeout.
module fourier_result_sequencer #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic              core_done,
    output logic [31:0]       reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              run_done,
    output logic              timeout_err
);

    localparam int CNT_W  = $clog2(N_POINTS + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] STREAM    = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  issued;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load;
    logic              accept_last;
    logic              timed_out;

    assign busy        = (state != IDLE);
    assign load        = (state == STREAM) && (issued < CNT_W'(N_POINTS)) &&
                         (!out_valid || out_ready);
    assign accept_last = (state == STREAM) && out_valid && out_last && out_ready;
    // core_done takes priority over a timeout landing on the same cycle
    assign timed_out   = (state == WAIT_DONE) && !core_done &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            reg_addr    <= '0;
            issued      <= '0;
            wait_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            run_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            run_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_DONE;
                        reg_addr <= '0;
                        issued   <= '0;
                        wait_cnt <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        state <= STREAM;
                    end else if (timed_out) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                STREAM: begin
                    if (load) begin
                        out_data  <= reg_data;
                        out_valid <= 1'b1;
                        out_last  <= (reg_addr == 32'(N_POINTS - 1));
                        reg_addr  <= reg_addr + 32'd1;
                        issued    <= issued + CNT_W'(1);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // the final word has no load behind it, so the branch above clears the output
                    if (accept_last) begin
                        state    <= IDLE;
                        run_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fourier_result_sequencer.sv
// Directed bench for fourier_result_sequencer: full run, backpressure, timeout,
// start while busy, mid-run reset and the core_done/timeout tie.
module tb_fourier_result_sequencer;

    localparam int N_PTS = 64;
    localparam int DW    = 32;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          core_done = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [31:0]   reg_addr;
    logic [DW-1:0] reg_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          run_done;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    assign reg_data = reg_addr + 32'd100;

    always #5 clk = ~clk;

    fourier_result_sequencer #(
        .N_POINTS(N_PTS),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .core_done  (core_done),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .run_done   (run_done),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses start for one cycle; returns at the first negedge inside WAIT_DONE.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_addr", reg_addr, 0);
    endtask

    // Call at the negedge where core_done was raised; consumes words via a scoreboard.
    task automatic stream(input int pat, input int stop_after, input bit start_mid,
                          output int accepted, output int last_cyc);
        logic [31:0]   exp_word;
        logic [DW-1:0] held_data;
        logic [31:0]   held_addr;
        logic          held_last;
        bit            stalled;
        exp_word = 32'd100;
        accepted = 0;
        last_cyc = -1;
        stalled  = 1'b0;
        held_data = '0;
        held_addr = '0;
        held_last = 1'b0;
        for (int cyc = 0; cyc < 400 && accepted < stop_after; cyc++) begin
            @(negedge clk);
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            start     = (start_mid && cyc == 5);
            if (cyc == 3) core_done = 1'b0;
            if (cyc == 0) begin
                check("enter_busy", busy, 1);
                check("enter_no_timeout", timeout_err, 0);
                check("first_valid_latency", out_valid, 0);
            end
            if (cyc == 1) check("first_valid_rise", out_valid, 1);
            if (stalled) begin
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
                check("stall_addr", reg_addr, held_addr);
            end
            if (out_valid && out_ready) begin
                check("word_data", out_data, exp_word);
                check("word_last", out_last, exp_word == 32'd163);
                exp_word = exp_word + 32'd1;
                accepted++;
                last_cyc = cyc;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_addr = reg_addr;
            held_last = out_last;
        end
        start = 1'b0;
        check("word_count", accepted, stop_after);
    endtask

    task automatic finish_checks();
        @(negedge clk);
        check("run_done_pulse", run_done, 1);
        check("end_idle", busy, 0);
        check("end_valid", out_valid, 0);
        check("end_last", out_last, 0);
        check("end_addr", reg_addr, 64);
        @(negedge clk);
        check("run_done_clear", run_done, 0);
        check("addr_no_wrap", reg_addr, 64);
    endtask

    initial begin
        int acc;
        int lc;

        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_flags", {out_last, run_done, timeout_err}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Full run, core_done three cycles after start
        do_start();
        repeat (2) @(negedge clk);
        core_done = 1'b1;
        stream(0, 64, 1'b0, acc, lc);
        check("full_throughput", lc, 64);
        finish_checks();

        // Backpressure 1,0,0,1
        do_start();
        core_done = 1'b1;
        stream(1, 64, 1'b0, acc, lc);
        finish_checks();

        // Timeout with core_done held low
        core_done = 1'b0;
        do_start();
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i < TO) begin
                check("wait_busy", busy, 1);
                check("wait_no_timeout", timeout_err, 0);
            end else begin
                check("timeout_pulse", timeout_err, 1);
                check("timeout_idle", busy, 0);
            end
            check("wait_no_valid", out_valid, 0);
        end
        @(negedge clk);
        check("timeout_clear", timeout_err, 0);
        check("timeout_no_valid", out_valid, 0);

        // Start while busy
        do_start();
        core_done = 1'b1;
        stream(0, 64, 1'b1, acc, lc);
        finish_checks();

        // Mid-run reset after 10 accepted words
        do_start();
        core_done = 1'b1;
        stream(0, 10, 1'b0, acc, lc);
        check("pre_reset_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_addr", reg_addr, 0);
        check("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_resume_busy", busy, 0);
            check("no_resume_valid", out_valid, 0);
        end
        do_start();
        core_done = 1'b1;
        stream(0, 64, 1'b0, acc, lc);
        finish_checks();

        // Tie: core_done rises on the last wait cycle
        core_done = 1'b0;
        do_start();
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (i == TO - 1) core_done = 1'b1;
        end
        stream(0, 64, 1'b0, acc, lc);
        finish_checks();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fourier_result_sequencer.md
FOURIER_RESULT_SEQUENCER -- requirements
Module: fourier_result_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- N_POINTS, 64, number of result words streamed per transform.
- DATA_W, 32, result word width.
- TIMEOUT, 4096, maximum WAIT_DONE cycles before abort.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one readout run; sampled in IDLE only.
- busy  out  1  high in any state other than IDLE.
- core_done  in  1  transform-complete level from the Fourier core.
- reg_addr  out  32  result register index driven to the core.
- reg_data  in  DATA_W  core result; combinational function of reg_addr, valid in the same cycle.
- out_data  out  DATA_W  streamed result word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  marks word index N_POINTS-1.
- run_done  out  1  one-cycle pulse when the last word is accepted.
- timeout_err  out  1  one-cycle pulse on WAIT_DONE abort.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT_DONE, STREAM.
REQ-004 IDLE -> WAIT_DONE SHALL occur on the edge where start=1. The same edge SHALL:
- clear reg_addr to 0;
- clear the issued-word counter;
- clear the wait counter.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 In WAIT_DONE, core_done=1 SHALL move to STREAM on the next edge.
REQ-007 In WAIT_DONE, the wait counter SHALL increment each cycle core_done=0.
REQ-008 When the wait counter equals TIMEOUT-1 with core_done=0, the next edge SHALL:
- enter IDLE;
- pulse timeout_err for one cycle;
- produce no output words.
REQ-009 If core_done=1 and the timeout condition occur on the same cycle, core_done SHALL win and no timeout_err SHALL occur.
REQ-010 In STREAM, a load SHALL occur on any cycle where issued < N_POINTS and (out_valid=0 or out_ready=1). A load SHALL, on the next edge:
- set out_data <= reg_data and out_valid <= 1;
- set out_last <= (reg_addr == N_POINTS-1);
- increment reg_addr and issued.
REQ-011 When out_valid=1 and out_ready=1 with no load, out_valid SHALL clear on the next edge.
REQ-012 While out_valid=1 and out_ready=0, out_data, out_last and reg_addr SHALL hold stable.
REQ-013 With out_ready held at 1, the block SHALL sustain one word per cycle. The first out_valid SHALL rise one cycle after STREAM is entered.
REQ-014 When out_valid=1, out_last=1 and out_ready=1 are seen together, the next edge SHALL:
- enter IDLE;
- clear out_valid and out_last;
- pulse run_done for one cycle.
REQ-015 reg_addr SHALL stop at N_POINTS after the last load and SHALL NOT wrap; it SHALL return to 0 only at the next start.
REQ-016 core_done deasserting during STREAM SHALL NOT affect streaming.
REQ-017 busy SHALL be combinationally (state != IDLE).

Reset
REQ-018 reset=0 SHALL, asynchronously:
- force IDLE;
- set reg_addr, all counters, out_data, out_valid, out_last, run_done and timeout_err to 0.
REQ-019 Reset asserted mid-STREAM SHALL drop out_valid immediately. On release, the block SHALL wait in IDLE for a new start with no resumption.
REQ-020 Reset deassertion SHALL take effect at the first rising clk edge after release.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Full run: reg_data = addr+100, start, core_done=1 three cycles later, out_ready=1 -> 64 consecutive words 100..163, out_last only on 163, run_done one cycle after 163 accepted.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly -> no word lost or duplicated, out_data stable while stalled, 64 words total in order.
- Timeout: TIMEOUT=16, start, core_done held 0 -> timeout_err pulses 16 cycles after WAIT_DONE entry, busy falls, no out_valid.
- Start while busy: second start pulse during STREAM -> ignored, exactly 64 words, reg_addr ends at 64.
- Mid-run reset: reset=0 after 10 accepted words -> out_valid and reg_addr 0 within the same cycle; new start yields a full 64-word run from address 0.
- Tie case: core_done rises on the TIMEOUT-1 wait cycle -> STREAM entered, no timeout_err.
